// File: rtl/reg_port_sequencer_pkg.sv
// Shared constants for the register-file port sequencer: per-port sequence
// codes, byte/word flag values, FSM state encodings and the lane-index width helper.
// Latency: n/a (constants only). Backpressure: n/a.
package reg_port_sequencer_pkg;

  // Per-port sequence codes carried on REG_SEQX, two bits per port.
  localparam logic [1:0] SEQ_NONE   = 2'b00;  // port unused this instruction
  localparam logic [1:0] SEQ_READ   = 2'b01;  // read only
  localparam logic [1:0] SEQ_UPDATE = 2'b10;  // read, then byte-masked write
  localparam logic [1:0] SEQ_WRITE  = 2'b11;  // byte-masked write only

  // BYTEX values, one bit per port.
  localparam logic BYTEX_WORD = 1'b0;
  localparam logic BYTEX_BYTE = 1'b1;

  // Sequencer FSM states.
  localparam logic [1:0] ST_IDLE  = 2'b00;  // waiting for DECODE
  localparam logic [1:0] ST_ARMED = 2'b01;  // decoded, waiting for first EXECUTE
  localparam logic [1:0] ST_EXEC  = 2'b10;  // EXECUTE held by STALL
  localparam logic [1:0] ST_WRITE = 2'b11;  // write enables up, waiting for COMMIT

  // Width of the byte-lane index; never narrower than one bit so a
  // single-lane register still has a legal ADDR_LO port.
  function automatic int lane_bits(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

endpackage

// File: rtl/reg_lane_decode.sv
// Per-port decoder: turns a sequence code, byte/word flag and low address bits
// into a lane-enable mask plus port-enable and write-intent bits.
// Latency: combinational. Backpressure: none.
//
// Ports:
//   code      - 2-bit sequence code for this port
//   bytex     - 0 word access, 1 single byte lane
//   addr_lo   - byte address low bits, picks the lane in byte mode
//   lane_mask - lane enables for this port
//   en        - port takes part in the instruction
//   wen       - port will be written (UPDATE or WRITE)
module reg_lane_decode
  import reg_port_sequencer_pkg::*;
#(
  parameter int LANES = 2,
  parameter int LB    = 1
) (
  input  logic [1:0]       code,
  input  logic             bytex,
  input  logic [LB-1:0]    addr_lo,
  output logic [LANES-1:0] lane_mask,
  output logic             en,
  output logic             wen
);

  logic [LANES-1:0] byte_mask;

  // One-hot lane select. An out-of-range address (possible when LANES is
  // not a power of two) saturates onto the top lane instead of selecting
  // nothing, so a byte write never silently disappears.
  always_comb begin
    byte_mask = '0;
    for (int l = 0; l < LANES; l++) begin
      if ((int'(addr_lo) == l) || ((l == LANES - 1) && (int'(addr_lo) >= LANES))) begin
        byte_mask[l] = 1'b1;
      end
    end
  end

  always_comb begin
    lane_mask = '0;
    en        = 1'b0;
    wen       = 1'b0;
    case (code)
      SEQ_NONE: begin
        lane_mask = '0;
      end
      SEQ_READ: begin
        // Reads always fetch the whole register; BYTEX only shapes writes.
        en        = 1'b1;
        lane_mask = '1;
      end
      SEQ_UPDATE, SEQ_WRITE: begin
        en  = 1'b1;
        wen = 1'b1;
        case (bytex)
          BYTEX_WORD: lane_mask = '1;
          BYTEX_BYTE: lane_mask = byte_mask;
          default:    lane_mask = '1;
        endcase
      end
      default: begin
        lane_mask = '0;
      end
    endcase
  end

endmodule

// File: rtl/reg_port_sequencer.sv
// Register-file port sequencer: captures per-port codes at DECODE and drives
// port/lane enables through EXECUTE and write enables into the COMMIT cycle.
// Latency: outputs registered, one edge after the phase strobe. Backpressure: STALL holds EXECUTE.
//
// Ports:
//   CLK, RESET                     - clock, synchronous active-high reset
//   FETCH/DECODE/EXECUTE/COMMIT    - one-hot phase strobes
//   STALL                          - holds the EXECUTE phase (looked at only with EXECUTE)
//   REG_SEQX, BYTEX, ADDR_LO       - per-instruction port codes, sampled at DECODE only
//   REG_EN, REG_WEN, REG_BYTE_EN   - register-file port, write and lane enables
//   BUSY                           - a sequence is in flight
//   SEQ_ERR                        - sticky phase-order / one-hot violation flag
module reg_port_sequencer
  import reg_port_sequencer_pkg::*;
#(
  parameter  int DATA_WIDTH = 16,
  parameter  int NPORTS     = 2,
  localparam int LANES      = DATA_WIDTH / 8,
  localparam int LB         = lane_bits(LANES)
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    FETCH,
  input  logic                    DECODE,
  input  logic                    EXECUTE,
  input  logic                    COMMIT,
  input  logic                    STALL,
  input  logic [2*NPORTS-1:0]     REG_SEQX,
  input  logic [NPORTS-1:0]       BYTEX,
  input  logic [LB-1:0]           ADDR_LO,
  output logic [NPORTS-1:0]       REG_EN,
  output logic [NPORTS-1:0]       REG_WEN,
  output logic [NPORTS*LANES-1:0] REG_BYTE_EN,
  output logic                    BUSY,
  output logic                    SEQ_ERR
);

  logic [1:0]               state;
  logic [NPORTS-1:0]        wen_intent;  // write intent captured at DECODE
  logic [NPORTS-1:0]        dec_en;
  logic [NPORTS-1:0]        dec_wen;
  logic [NPORTS*LANES-1:0]  dec_mask;
  logic                     multi_hot;
  logic                     order_err;
  logic                     seq_fault;

  // ---------------------------------------------------------------------
  // Per-port decode of the incoming instruction fields
  // ---------------------------------------------------------------------
  for (genvar p = 0; p < NPORTS; p++) begin : g_port
    reg_lane_decode #(
      .LANES (LANES),
      .LB    (LB)
    ) u_lane_decode (
      .code      (REG_SEQX[2*p+1:2*p]),
      .bytex     (BYTEX[p]),
      .addr_lo   (ADDR_LO),
      .lane_mask (dec_mask[LANES*p +: LANES]),
      .en        (dec_en[p]),
      .wen       (dec_wen[p])
    );
  end

  // ---------------------------------------------------------------------
  // Phase-order checking. FETCH is left out: it outranks error detection,
  // so FETCH together with any other strobe is a clean abort.
  // ---------------------------------------------------------------------
  always_comb begin
    multi_hot = (DECODE & EXECUTE) | (DECODE & COMMIT) | (EXECUTE & COMMIT);
    order_err = (DECODE  && (state != ST_IDLE))
             || (EXECUTE && ((state == ST_IDLE) || (state == ST_WRITE)))
             || (COMMIT  && (state != ST_WRITE));
    seq_fault = multi_hot | order_err;
  end

  // ---------------------------------------------------------------------
  // Sequencer FSM and output registers
  // ---------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= ST_IDLE;
      REG_EN      <= '0;
      REG_WEN     <= '0;
      REG_BYTE_EN <= '0;
      wen_intent  <= '0;
      SEQ_ERR     <= 1'b0;
    end else if (FETCH) begin
      // Abort whatever is in flight; not an error.
      state       <= ST_IDLE;
      REG_EN      <= '0;
      REG_WEN     <= '0;
      REG_BYTE_EN <= '0;
      wen_intent  <= '0;
    end else if (seq_fault) begin
      state       <= ST_IDLE;
      REG_EN      <= '0;
      REG_WEN     <= '0;
      REG_BYTE_EN <= '0;
      wen_intent  <= '0;
      SEQ_ERR     <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (DECODE) begin
            state       <= ST_ARMED;
            REG_EN      <= dec_en;
            REG_BYTE_EN <= dec_mask;
            wen_intent  <= dec_wen;
          end
        end
        ST_ARMED: begin
          // An unstalled first EXECUTE goes straight to WRITE so the write
          // enables land in the COMMIT cycle; a stalled one parks in EXEC.
          if (EXECUTE) begin
            if (STALL) begin
              state <= ST_EXEC;
            end else begin
              state   <= ST_WRITE;
              REG_WEN <= wen_intent;
            end
          end
        end
        ST_EXEC: begin
          if (EXECUTE && !STALL) begin
            state   <= ST_WRITE;
            REG_WEN <= wen_intent;
          end
        end
        ST_WRITE: begin
          if (COMMIT) begin
            state       <= ST_IDLE;
            REG_EN      <= '0;
            REG_WEN     <= '0;
            REG_BYTE_EN <= '0;
            wen_intent  <= '0;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Straight from the state register, so still free of input-to-output paths.
  assign BUSY = (state != ST_IDLE);

endmodule

// File: tb/tb_reg_port_sequencer.sv
// Testbench for reg_port_sequencer: a 16-bit/2-port instance driven from a
// cycle-by-cycle vector table through an expected-result queue, plus a
// 32-bit/3-port instance exercised by a hand-written sequence.
module tb_reg_port_sequencer;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic RESET, FETCH, DECODE, EXECUTE, COMMIT, STALL;

  // 16-bit, 2-port instance
  logic [3:0]  seqx1;
  logic [1:0]  bytex1;
  logic [0:0]  addr1;
  logic [1:0]  en1, wen1;
  logic [3:0]  be1;
  logic        busy1, err1;

  // 32-bit, 3-port instance
  logic [5:0]  seqx2;
  logic [2:0]  bytex2;
  logic [1:0]  addr2;
  logic [2:0]  en2, wen2;
  logic [11:0] be2;
  logic        busy2, err2;

  int checks = 0;
  int errors = 0;

  reg_port_sequencer #(.DATA_WIDTH(16), .NPORTS(2)) dut1 (
    .CLK(CLK), .RESET(RESET), .FETCH(FETCH), .DECODE(DECODE), .EXECUTE(EXECUTE),
    .COMMIT(COMMIT), .STALL(STALL), .REG_SEQX(seqx1), .BYTEX(bytex1), .ADDR_LO(addr1),
    .REG_EN(en1), .REG_WEN(wen1), .REG_BYTE_EN(be1), .BUSY(busy1), .SEQ_ERR(err1)
  );

  reg_port_sequencer #(.DATA_WIDTH(32), .NPORTS(3)) dut2 (
    .CLK(CLK), .RESET(RESET), .FETCH(FETCH), .DECODE(DECODE), .EXECUTE(EXECUTE),
    .COMMIT(COMMIT), .STALL(STALL), .REG_SEQX(seqx2), .BYTEX(bytex2), .ADDR_LO(addr2),
    .REG_EN(en2), .REG_WEN(wen2), .REG_BYTE_EN(be2), .BUSY(busy2), .SEQ_ERR(err2)
  );

  // One row = one clock cycle of stimulus and the outputs expected after that edge.
  typedef struct {
    string      name;
    logic [5:0] strb;   // {RESET, FETCH, DECODE, EXECUTE, COMMIT, STALL}
    logic [3:0] seqx;
    logic [1:0] bytex;
    logic       addr;
    logic [9:0] exp;    // {REG_EN[1:0], REG_WEN[1:0], REG_BYTE_EN[3:0], BUSY, SEQ_ERR}
  } row_t;

  typedef struct {
    string      name;
    logic [9:0] exp;
  } exp_t;

  row_t tbl[$];
  exp_t sb[$];

  // Strobe shorthands
  localparam logic [5:0] S_RST  = 6'b100000;
  localparam logic [5:0] S_FET  = 6'b010000;
  localparam logic [5:0] S_DEC  = 6'b001000;
  localparam logic [5:0] S_EXE  = 6'b000100;
  localparam logic [5:0] S_STL  = 6'b000101;
  localparam logic [5:0] S_COM  = 6'b000010;
  localparam logic [5:0] S_NOP  = 6'b000000;
  localparam logic [5:0] S_DX   = 6'b001100;
  localparam logic [5:0] S_FDX  = 6'b011100;

  function automatic row_t mk(string n, logic [5:0] s, logic [3:0] sq, logic [1:0] bx,
                              logic ad, logic [1:0] en, logic [1:0] wen, logic [3:0] be,
                              logic busy, logic err);
    row_t r;
    r.name  = n;
    r.strb  = s;
    r.seqx  = sq;
    r.bytex = bx;
    r.addr  = ad;
    r.exp   = {en, wen, be, busy, err};
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic drive_strobes(input logic [5:0] s);
    {RESET, FETCH, DECODE, EXECUTE, COMMIT, STALL} = s;
  endtask

  // Drive a row, queue its expectation, and compare once the edge has passed.
  task automatic apply_row(input row_t r);
    exp_t e;
    exp_t got_e;
    drive_strobes(r.strb);
    seqx1  = r.seqx;
    bytex1 = r.bytex;
    addr1  = r.addr;
    e.name = r.name;
    e.exp  = r.exp;
    sb.push_back(e);
    @(posedge CLK);
    #1;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      got_e = sb.pop_front();
      check(got_e.name, 32'({en1, wen1, be1, busy1, err1}), 32'(got_e.exp));
    end
  endtask

  task automatic step(input logic [5:0] s);
    drive_strobes(s);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    drive_strobes(S_RST);
    seqx1 = '0; bytex1 = '0; addr1 = '0;
    seqx2 = '0; bytex2 = '0; addr2 = '0;

    // ---- reset state of both instances ----
    step(S_RST);
    check("rst_dut1", 32'({en1, wen1, be1, busy1, err1}), 32'd0);
    check("rst_dut2", 32'({en2, wen2, be2, busy2, err2}), 32'd0);

    // ---- 32-bit / 3-port: port 2 WRITE byte at lane 3 ----
    seqx2 = 6'b110000; bytex2 = 3'b100; addr2 = 2'd3;
    step(S_DEC);
    seqx2 = '0; bytex2 = '0; addr2 = '0;   // ignored after DECODE
    check("w32_dec_be",  32'(be2),  32'h800);
    check("w32_dec_en",  32'(en2),  32'b100);
    check("w32_dec_wen", 32'(wen2), 32'b000);
    step(S_EXE);
    check("w32_exe_wen", 32'(wen2), 32'b100);
    check("w32_exe_be",  32'(be2),  32'h800);
    step(S_COM);
    check("w32_com_clr", 32'({en2, wen2, be2, busy2, err2}), 32'd0);

    // ---- 32-bit / 3-port: port 0 WRITE byte lane 1, port 1 READ (byte flag ignored) ----
    seqx2 = 6'b000111; bytex2 = 3'b011; addr2 = 2'd1;
    step(S_DEC);
    check("w32b_dec_be", 32'(be2), 32'h0F2);
    check("w32b_dec_en", 32'(en2), 32'b011);
    step(S_EXE);
    check("w32b_exe_wen", 32'(wen2), 32'b001);
    step(S_COM);
    check("w32b_com_busy", 32'(busy2), 32'd0);
    seqx2 = '0; bytex2 = '0; addr2 = '0;

    // ---- 16-bit / 2-port vector table ----
    tbl.push_back(mk("rst",          S_RST, 4'b0000, 2'b00, 1'b0, 2'b00, 2'b00, 4'b0000, 1'b0, 1'b0));
    // port 0 READ, port 1 WRITE word
    tbl.push_back(mk("a_dec",        S_DEC, 4'b1101, 2'b00, 1'b0, 2'b11, 2'b00, 4'b1111, 1'b1, 1'b0));
    tbl.push_back(mk("a_exe",        S_EXE, 4'b1101, 2'b00, 1'b0, 2'b11, 2'b10, 4'b1111, 1'b1, 1'b0));
    tbl.push_back(mk("a_com",        S_COM, 4'b1101, 2'b00, 1'b0, 2'b00, 2'b00, 4'b0000, 1'b0, 1'b0));
    tbl.push_back(mk("a_idle",       S_NOP, 4'b1101, 2'b00, 1'b0, 2'b00, 2'b00, 4'b0000, 1'b0, 1'b0));
    // port 0 UPDATE byte, lane 1 then lane 0
    tbl.push_back(mk("b1_dec",       S_DEC, 4'b0010, 2'b01, 1'b1, 2'b01, 2'b00, 4'b0010, 1'b1, 1'b0));
    tbl.push_back(mk("b1_exe",       S_EXE, 4'b0010, 2'b01, 1'b1, 2'b01, 2'b01, 4'b0010, 1'b1, 1'b0));
    tbl.push_back(mk("b1_com",       S_COM, 4'b0010, 2'b01, 1'b1, 2'b00, 2'b00, 4'b0000, 1'b0, 1'b0));
    tbl.push_back(mk("b0_dec",       S_DEC, 4'b0010, 2'b01, 1'b0, 2'b01, 2'b00, 4'b0001, 1'b1, 1'b0));
    tbl.push_back(mk("b0_exe_newin", S_EXE, 4'b1111, 2'b00, 1'b1, 2'b01, 2'b01, 4'b0001, 1'b1, 1'b0));
    tbl.push_back(mk("b0_com",       S_COM, 4'b1111, 2'b00, 1'b1, 2'b00, 2'b00, 4'b0000, 1'b0, 1'b0));
    // three stalled EXECUTEs
    tbl.push_back(mk("c_dec",        S_DEC, 4'b1101, 2'b00, 1'b0, 2'b11, 2'b00, 4'b1111, 1'b1, 1'b0));
    tbl.push_back(mk("c_stall1",     S_STL, 4'b1101, 2'b00, 1'b0, 2'b11, 2'b00, 4'b1111, 1'b1, 1'b0));
    tbl.push_back(mk("c_stall2",     S_STL, 4'b1101, 2'b00, 1'b0, 2'b11, 2'b00, 4'b1111, 1'b1, 1'b0));
    tbl.push_back(mk("c_stall3",     S_STL, 4'b1101, 2'b00, 1'b0, 2'b11, 2'b00, 4'b1111, 1'b1, 1'b0));
    tbl.push_back(mk("c_exe",        S_EXE, 4'b1101, 2'b00, 1'b0, 2'b11, 2'b10, 4'b1111, 1'b1, 1'b0));
    tbl.push_back(mk("c_com",        S_COM, 4'b1101, 2'b00, 1'b0, 2'b00, 2'b00, 4'b0000, 1'b0, 1'b0));
    // FETCH abort from EXEC, then a fresh sequence is accepted
    tbl.push_back(mk("d_dec",        S_DEC, 4'b1101, 2'b00, 1'b0, 2'b11, 2'b00, 4'b1111, 1'b1, 1'b0));
    tbl.push_back(mk("d_stall",      S_STL, 4'b1101, 2'b00, 1'b0, 2'b11, 2'b00, 4'b1111, 1'b1, 1'b0));
    tbl.push_back(mk("d_fetch",      S_FET, 4'b1101, 2'b00, 1'b0, 2'b00, 2'b00, 4'b0000, 1'b0, 1'b0));
    tbl.push_back(mk("d_dec2",       S_DEC, 4'b0011, 2'b00, 1'b0, 2'b01, 2'b00, 4'b0011, 1'b1, 1'b0));
    tbl.push_back(mk("d_exe2",       S_EXE, 4'b0011, 2'b00, 1'b0, 2'b01, 2'b01, 4'b0011, 1'b1, 1'b0));
    tbl.push_back(mk("d_com2",       S_COM, 4'b0011, 2'b00, 1'b0, 2'b00, 2'b00, 4'b0000, 1'b0, 1'b0));
    tbl.push_back(mk("fetch_multi",  S_FDX, 4'b1101, 2'b00, 1'b0, 2'b00, 2'b00, 4'b0000, 1'b0, 1'b0));
    // COMMIT in ARMED, then DECODE+EXECUTE together; error is sticky
    tbl.push_back(mk("e_dec",        S_DEC, 4'b1101, 2'b00, 1'b0, 2'b11, 2'b00, 4'b1111, 1'b1, 1'b0));
    tbl.push_back(mk("e_com_armed",  S_COM, 4'b1101, 2'b00, 1'b0, 2'b00, 2'b00, 4'b0000, 1'b0, 1'b1));
    tbl.push_back(mk("e_sticky",     S_NOP, 4'b1101, 2'b00, 1'b0, 2'b00, 2'b00, 4'b0000, 1'b0, 1'b1));
    tbl.push_back(mk("e_dec_again",  S_DEC, 4'b1101, 2'b00, 1'b0, 2'b11, 2'b00, 4'b1111, 1'b1, 1'b1));
    tbl.push_back(mk("e_dec_exe",    S_DX,  4'b1101, 2'b00, 1'b0, 2'b00, 2'b00, 4'b0000, 1'b0, 1'b1));
    tbl.push_back(mk("e_dec_mid",    S_DEC, 4'b1101, 2'b00, 1'b0, 2'b11, 2'b00, 4'b1111, 1'b1, 1'b1));
    tbl.push_back(mk("e_rst_mid",    S_RST, 4'b1101, 2'b00, 1'b0, 2'b00, 2'b00, 4'b0000, 1'b0, 1'b0));
    // EXECUTE in IDLE
    tbl.push_back(mk("f_exe_idle",   S_EXE, 4'b1101, 2'b00, 1'b0, 2'b00, 2'b00, 4'b0000, 1'b0, 1'b1));
    tbl.push_back(mk("f_rst",        S_RST, 4'b1101, 2'b00, 1'b0, 2'b00, 2'b00, 4'b0000, 1'b0, 1'b0));
    // EXECUTE in WRITE
    tbl.push_back(mk("g_dec",        S_DEC, 4'b1101, 2'b00, 1'b0, 2'b11, 2'b00, 4'b1111, 1'b1, 1'b0));
    tbl.push_back(mk("g_exe",        S_EXE, 4'b1101, 2'b00, 1'b0, 2'b11, 2'b10, 4'b1111, 1'b1, 1'b0));
    tbl.push_back(mk("g_exe_write",  S_EXE, 4'b1101, 2'b00, 1'b0, 2'b00, 2'b00, 4'b0000, 1'b0, 1'b1));
    tbl.push_back(mk("g_rst",        S_RST, 4'b1101, 2'b00, 1'b0, 2'b00, 2'b00, 4'b0000, 1'b0, 1'b0));
    // COMMIT while stalled in EXEC
    tbl.push_back(mk("h_dec",        S_DEC, 4'b1101, 2'b00, 1'b0, 2'b11, 2'b00, 4'b1111, 1'b1, 1'b0));
    tbl.push_back(mk("h_stall",      S_STL, 4'b1101, 2'b00, 1'b0, 2'b11, 2'b00, 4'b1111, 1'b1, 1'b0));
    tbl.push_back(mk("h_com_exec",   S_COM, 4'b1101, 2'b00, 1'b0, 2'b00, 2'b00, 4'b0000, 1'b0, 1'b1));
    tbl.push_back(mk("h_rst",        S_RST, 4'b1101, 2'b00, 1'b0, 2'b00, 2'b00, 4'b0000, 1'b0, 1'b0));

    foreach (tbl[i]) begin
      apply_row(tbl[i]);
    end

    drive_strobes(S_NOP);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
